// File: rtl/toast_mem_pkg.sv
// Shared definitions for the toast memory responder: register window layout and region decode.
package toast_mem_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [3:0] MMIO_OFF_GPIO   = 4'h0;
  localparam logic [3:0] MMIO_OFF_CYCLE  = 4'h4;
  localparam logic [3:0] MMIO_OFF_HALT   = 4'h8;
  localparam logic [3:0] MMIO_OFF_STORES = 4'hC;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_MMIO = 2'd2
  } region_e;

  // RAM wins if the two windows ever overlap; the 33-bit limit allows a 4 GiB RAM bound.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [32:0] ram_bytes,
                                            input logic [31:0] base);
    if ({1'b0, addr} < ram_bytes) begin
      return REGION_RAM;
    end else if (addr[31:4] == base[31:4]) begin
      return REGION_MMIO;
    end else begin
      return REGION_NONE;
    end
  endfunction

endpackage

// File: rtl/toast_mem_responder_if.sv
// Core MEM-stage bus plus the responder's observable outputs.
interface toast_mem_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_en;
  logic        mem_rst;
  logic [31:0] mem_rd_data;
  logic [31:0] gpio_out;
  logic        sim_halt;

  modport master (
    output mem_addr, mem_wr_data, mem_wr_en, mem_rst,
    input  mem_rd_data, gpio_out, sim_halt
  );

  modport slave (
    input  mem_addr, mem_wr_data, mem_wr_en, mem_rst,
    output mem_rd_data, gpio_out, sim_halt
  );
endinterface

// File: rtl/toast_sram.sv
// Single-port word RAM with registered, read-first output; storage is never reset.
module toast_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/toast_mem_responder.sv
// Memory/MMIO responder for the core MEM stage: word RAM plus a GPIO/CYCLE/HALT/STORES window.
module toast_mem_responder
  import toast_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input logic                  Clk,
  input logic                  Reset,
  toast_mem_responder_if.slave bus
);
  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  region_e     region_d, region_q;
  logic [31:0] gpio_d, gpio_q;
  logic [31:0] cycle_d, cycle_q;
  logic [31:0] stores_d, stores_q;
  logic [31:0] mmio_rdata_d, mmio_rdata_q;
  logic        halt_d, halt_q;
  logic        wr_accept;
  logic        ram_we;
  logic [3:0]  mmio_off;
  logic [31:0] ram_rdata;

  always_comb begin
    region_d  = decode_region(bus.mem_addr, RAM_BYTES, MMIO_BASE);
    mmio_off  = {bus.mem_addr[3:2], 2'b00};
    wr_accept = bus.mem_wr_en && (region_d != REGION_NONE);
    // Reset is asynchronous, so a write coinciding with it must be blocked here too.
    ram_we    = wr_accept && (region_d == REGION_RAM) && !Reset;
  end

  toast_sram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk_i  (Clk),
    .addr_i (bus.mem_addr[AW+1:2]),
    .we_i   (ram_we),
    .wdata_i(bus.mem_wr_data),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    gpio_d       = gpio_q;
    halt_d       = halt_q;
    cycle_d      = cycle_q + 32'd1;
    stores_d     = stores_q + {31'd0, wr_accept};
    mmio_rdata_d = 32'd0;
    case (mmio_off)
      MMIO_OFF_GPIO:   mmio_rdata_d = gpio_q;
      MMIO_OFF_CYCLE:  mmio_rdata_d = cycle_q;
      MMIO_OFF_HALT:   mmio_rdata_d = {31'd0, halt_q};
      MMIO_OFF_STORES: mmio_rdata_d = stores_q;
      default:         mmio_rdata_d = 32'd0;
    endcase
    if (wr_accept && (region_d == REGION_MMIO)) begin
      if (mmio_off == MMIO_OFF_GPIO) begin
        gpio_d = bus.mem_wr_data;
      end
      if ((mmio_off == MMIO_OFF_HALT) && (bus.mem_wr_data != 32'd0)) begin
        halt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      region_q     <= REGION_NONE;
      gpio_q       <= 32'd0;
      cycle_q      <= 32'd0;
      stores_q     <= 32'd0;
      mmio_rdata_q <= 32'd0;
      halt_q       <= 1'b0;
    end else begin
      // Dropping the sampled region to NONE is what zeroes the next read on mem_rst.
      region_q     <= bus.mem_rst ? REGION_NONE : region_d;
      gpio_q       <= gpio_d;
      cycle_q      <= cycle_d;
      stores_q     <= stores_d;
      mmio_rdata_q <= mmio_rdata_d;
      halt_q       <= halt_d;
    end
  end

  always_comb begin
    bus.mem_rd_data = 32'd0;
    case (region_q)
      REGION_RAM:  bus.mem_rd_data = ram_rdata;
      REGION_MMIO: bus.mem_rd_data = mmio_rdata_q;
      default:     bus.mem_rd_data = 32'd0;
    endcase
  end

  assign bus.gpio_out = gpio_q;
  assign bus.sim_halt = halt_q;
endmodule

// File: doc/toast_mem_responder.md
TOAST_MEM_RESPONDER -- requirements
Module: toast_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter MMIO_BASE, default 32'h8000_0000, base address of the register window.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_addr  input  32  byte address from core MEM stage.
REQ-006 SHALL have port mem_wr_data  input  32  store data.
REQ-007 SHALL have port mem_wr_en  input  1  word write strobe, one cycle per store.
REQ-008 SHALL have port mem_rst  input  1  synchronous clear of the read-data register.
REQ-009 SHALL have port mem_rd_data  output  32  registered read data to core.
REQ-010 SHALL have port gpio_out  output  32  MMIO output register value.
REQ-011 SHALL have port sim_halt  output  1  sticky halt flag for testbench termination.

Function
REQ-012 SHALL decode RAM region as mem_addr < DEPTH_WORDS*4; word index = mem_addr[log2(DEPTH_WORDS)+1:2]; mem_addr[1:0] ignored.
REQ-013 SHALL decode MMIO region as mem_addr[31:4] == MMIO_BASE[31:4]; offsets 0x0 GPIO (R/W), 0x4 CYCLE (RO), 0x8 HALT (W, reads 0/1), 0xC STORES (RO).
REQ-014 SHALL return read data with exactly one cycle latency: mem_rd_data after edge N reflects mem_addr sampled at edge N.
REQ-015 SHALL perform a full-word write at the rising edge where mem_wr_en=1 to the decoded location.
REQ-016 SHALL be read-first: read and write to same RAM word in one cycle returns old contents; new contents visible the following cycle.
REQ-017 SHALL ignore writes and return 32'h0 for addresses outside both regions; no error signalled.
REQ-018 SHALL drive mem_rd_data to 32'h0 at the next edge when mem_rst=1, overriding any read in that cycle; RAM and MMIO writes in that cycle still occur.
REQ-019 SHALL increment CYCLE by 1 every cycle out of reset, wrapping 32'hFFFF_FFFF -> 0; writes to CYCLE ignored.
REQ-020 SHALL increment STORES on every accepted write (RAM or MMIO), wrapping at 2^32; writes to STORES ignored.
REQ-021 SHALL set sim_halt on any write to HALT with mem_wr_data != 0; sim_halt stays 1 until Reset; writing 0 has no effect.
REQ-022 SHALL update gpio_out at the edge of a GPIO write; a same-cycle GPIO read returns the old value.

Reset
REQ-023 SHALL on Reset=1 immediately force mem_rd_data=0, gpio_out=0, sim_halt=0, CYCLE=0, STORES=0.
REQ-024 SHALL NOT reset RAM contents; Reset asserted mid-write SHALL suppress that write.
REQ-025 SHALL begin counting CYCLE at the first rising edge after Reset deasserts.

Structure
REQ-026 SHALL place MMIO_BASE default, register offsets (GPIO/CYCLE/HALT/STORES) and region-decode enum in shared package toast_mem_pkg.
REQ-027 SHALL instantiate one sub-module toast_sram: single-port, read-first, registered-output RAM array, DEPTH_WORDS parameter, no reset on storage.
REQ-028 SHALL register the decode result alongside the RAM output so the output mux selects RAM/MMIO/zero from the sampled address.

Verification
REQ-029 SHALL verify: write 32'hDEAD_BEEF to 0x10, read 0x10 next cycle -> mem_rd_data=32'hDEAD_BEEF one cycle after read address.
REQ-030 SHALL verify: same-cycle write 32'h1234_5678 and read at 0x10 holding 32'hDEAD_BEEF -> returns 32'hDEAD_BEEF, next read returns 32'h1234_5678.
REQ-031 SHALL verify: read 0x10 with mem_rst=1 -> mem_rd_data=0; write 32'h5 to 0x0000_1000 (DEPTH 1024) -> ignored, read returns 0, STORES unchanged.
REQ-032 SHALL verify: write 32'hA5 to MMIO_BASE+0x0 -> gpio_out=32'hA5 next cycle; write 0 then 1 to MMIO_BASE+0x8 -> sim_halt stays 0 then latches 1.
REQ-033 SHALL verify: read MMIO_BASE+0x4 at cycles 10 and 20 after reset -> values differ by exactly 10; force CYCLE to 32'hFFFF_FFFF -> next value 0.
REQ-034 SHALL verify: assert Reset between edges with sim_halt=1, gpio_out=32'hA5 -> both 0 without waiting for a clock edge; RAM word at 0x10 retained.
